// File: rtl/hls_run_controller_pkg.sv
// Shared types and constants for the HLS run controller: FSM states,
// result status encodings and default field widths.
package hls_run_controller_pkg;

   localparam int CNT_W_DEF = 32;
   localparam int RUN_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      START,
      WAIT,
      REPORT
   } state_t;

   typedef enum logic [1:0] {
      STATUS_OK      = 2'b00,
      STATUS_TIMEOUT = 2'b01
   } status_t;

endpackage

// File: rtl/hls_cycle_counter.sv
// Run-length counter: loads to 1, increments while enabled, saturates at
// all-ones, and flags equality against a compare value.
module hls_cycle_counter #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] cmp_val,
   output logic [W-1:0] count,
   output logic         eq
);

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples its inputs from before the edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= W'(1);
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

   assign eq = (count == cmp_val);

endmodule

// File: rtl/hls_run_controller.sv
// Sequences a job of N accelerator runs: reset, start, measure the run
// length (with optional timeout) and hand each result to a consumer.
module hls_run_controller
   import hls_run_controller_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int RUN_W      = RUN_W_DEF,
   parameter int RST_CYCLES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [RUN_W-1:0] cfg_num_runs,
   input  logic [CNT_W-1:0] cfg_timeout,
   output logic             acc_reset,
   output logic             acc_start_port,
   input  logic             acc_done_port,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_cycles,
   output logic [RUN_W-1:0] res_index,
   output logic [1:0]       res_status,
   output logic             busy,
   output logic             all_done
);

   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [RUN_W-1:0] num_runs_q;
   logic [RUN_W-1:0] idx_q;
   logic [CNT_W-1:0] timeout_q;
   logic [RST_W-1:0] rst_cnt;
   logic [CNT_W-1:0] cycles_q;
   status_t          status_q;
   logic             all_done_q;
   logic [CNT_W-1:0] count;
   logic             cnt_eq;

   logic accept;
   logic rst_last;
   logic measuring;
   logic done_hit;
   logic tmo_hit;
   logic res_fire;
   logic more_runs;

   assign accept    = cfg_valid && (state == IDLE);
   assign rst_last  = (state == RST) && (rst_cnt == RST_W'(RST_CYCLES - 1));
   assign measuring = (state == START) || (state == WAIT);
   assign done_hit  = measuring && acc_done_port;
   // Done wins over a coincident timeout.
   assign tmo_hit   = measuring && !acc_done_port && (timeout_q != '0) && cnt_eq;
   assign res_fire  = (state == REPORT) && res_ready;
   assign more_runs = (({1'b0, idx_q} + (RUN_W + 1)'(1)) < {1'b0, num_runs_q});

   hls_cycle_counter #(
      .W (CNT_W)
   ) u_counter (
      .clock   (clock),
      .reset   (reset),
      .load    (rst_last),
      .inc     (measuring),
      .cmp_val (timeout_q),
      .count   (count),
      .eq      (cnt_eq)
   );

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt      = state;
      cfg_ready      = (state == IDLE);
      busy           = (state != IDLE);
      acc_reset      = 1'b1;
      acc_start_port = 1'b0;
      res_valid      = 1'b0;
      unique case (state)
         IDLE: begin
            acc_reset = 1'b0;
            if (accept && (cfg_num_runs != '0)) state_nxt = RST;
         end
         RST: begin
            acc_reset = 1'b0;
            if (rst_last) state_nxt = START;
         end
         START, WAIT: begin
            acc_start_port = (state == START);
            state_nxt      = (done_hit || tmo_hit) ? REPORT : WAIT;
         end
         REPORT: begin
            res_valid = 1'b1;
            if (res_fire) state_nxt = more_runs ? RST : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         num_runs_q <= '0;
         timeout_q  <= '0;
         idx_q      <= '0;
         rst_cnt    <= '0;
         all_done_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         all_done_q <= 1'b0;
         if (state == RST && !rst_last) rst_cnt <= rst_cnt + RST_W'(1);
         else                           rst_cnt <= '0;
         if (accept) begin
            num_runs_q <= cfg_num_runs;
            timeout_q  <= cfg_timeout;
            if (cfg_num_runs == '0) all_done_q <= 1'b1;
            else                    idx_q      <= '0;
         end
         if (res_fire) begin
            if (more_runs) idx_q      <= idx_q + RUN_W'(1);
            else           all_done_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cycles_q <= '0;
         status_q <= STATUS_OK;
      end else if (done_hit) begin
         cycles_q <= count;
         status_q <= STATUS_OK;
      end else if (tmo_hit) begin
         cycles_q <= timeout_q;
         status_q <= STATUS_TIMEOUT;
      end
   end

   assign res_cycles = cycles_q;
   assign res_index  = idx_q;
   assign res_status = status_q;
   assign all_done   = all_done_q;

endmodule

// File: tb/tb_hls_run_controller.sv
// Directed bench for hls_run_controller: single-run vector table plus
// hand-written multi-run, zero-run and mid-run reset sequences.
module tb_hls_run_controller;

   localparam int CNT_W = 32;
   localparam int RUN_W = 16;
   localparam int RST_CYCLES = 2;

   logic             clock = 1'b0;
   logic             reset;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [RUN_W-1:0] cfg_num_runs;
   logic [CNT_W-1:0] cfg_timeout;
   logic             acc_reset;
   logic             acc_start_port;
   logic             acc_done_port;
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] res_cycles;
   logic [RUN_W-1:0] res_index;
   logic [1:0]       res_status;
   logic             busy;
   logic             all_done;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   hls_run_controller #(
      .CNT_W      (CNT_W),
      .RUN_W      (RUN_W),
      .RST_CYCLES (RST_CYCLES)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_num_runs   (cfg_num_runs),
      .cfg_timeout    (cfg_timeout),
      .acc_reset      (acc_reset),
      .acc_start_port (acc_start_port),
      .acc_done_port  (acc_done_port),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_cycles     (res_cycles),
      .res_index      (res_index),
      .res_status     (res_status),
      .busy           (busy),
      .all_done       (all_done)
   );

   typedef struct {
      logic [CNT_W-1:0] timeout;
      int               lat;        // cycles after the start pulse; -1 = never
      int               stall;
      logic [CNT_W-1:0] exp_cycles;
      logic [1:0]       exp_status;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_acc_reset"}, acc_reset, 0);
      check({tag, "_start"}, acc_start_port, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res_cycles"}, res_cycles, 0);
      check({tag, "_res_index"}, res_index, 0);
      check({tag, "_res_status"}, res_status, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_all_done"}, all_done, 0);
      check({tag, "_cfg_ready"}, cfg_ready, 1);
   endtask

   // Called at a negedge in IDLE; returns at the negedge after acceptance.
   task automatic start_job(input int n, input logic [CNT_W-1:0] tmo);
      check("cfg_ready_idle", cfg_ready, 1);
      cfg_valid    = 1'b1;
      cfg_num_runs = RUN_W'(n);
      cfg_timeout  = tmo;
      @(negedge clock);
      cfg_valid = 1'b0;
   endtask

   // Called at the negedge of the first RST cycle; returns at the negedge
   // after the result handshake.
   task automatic do_run(input int idx, input int lat, input int stall,
                         input logic [CNT_W-1:0] exp_cyc, input logic [1:0] exp_st,
                         input bit poke);
      int rl = 0;
      int k = 0;
      int starts = 0;
      while (!acc_start_port && rl < 20) begin
         check("rst_acc_reset", acc_reset, 0);
         rl++;
         @(negedge clock);
      end
      check("rst_len", rl, RST_CYCLES);
      check("start_acc_reset", acc_reset, 1);
      while (!res_valid && k < 200) begin
         acc_done_port = (k == lat);
         starts += int'(acc_start_port);
         if (k == 0 && poke) begin
            check("cfg_ready_busy", cfg_ready, 0);
            cfg_valid    = 1'b1;
            cfg_num_runs = RUN_W'(1);
         end
         @(negedge clock);
         k++;
      end
      acc_done_port = 1'b0;
      cfg_valid     = 1'b0;
      check("start_pulses", starts, 1);
      check("res_valid", res_valid, 1);
      check("res_cycles", res_cycles, exp_cyc);
      check("res_status", res_status, exp_st);
      check("res_index", res_index, idx);
      for (int s = 0; s < stall; s++) begin
         res_ready = 1'b0;
         @(negedge clock);
         check("stall_valid", res_valid, 1);
         check("stall_cycles", res_cycles, exp_cyc);
         check("stall_status", res_status, exp_st);
         check("stall_index", res_index, idx);
      end
      res_ready = 1'b1;
      @(negedge clock);
      res_ready = 1'b0;
      check("res_valid_drop", res_valid, 0);
   endtask

   task automatic end_job();
      check("all_done_pulse", all_done, 1);
      check("busy_end", busy, 0);
      @(negedge clock);
      check("all_done_clear", all_done, 0);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{timeout: 0,  lat: 5,  stall: 0, exp_cycles: 6,  exp_status: 2'b00};
      vecs[1] = '{timeout: 10, lat: -1, stall: 0, exp_cycles: 10, exp_status: 2'b01};
      vecs[2] = '{timeout: 4,  lat: 3,  stall: 0, exp_cycles: 4,  exp_status: 2'b00};
      vecs[3] = '{timeout: 4,  lat: 4,  stall: 0, exp_cycles: 4,  exp_status: 2'b01};
      vecs[4] = '{timeout: 0,  lat: 0,  stall: 0, exp_cycles: 1,  exp_status: 2'b00};
      vecs[5] = '{timeout: 1,  lat: -1, stall: 0, exp_cycles: 1,  exp_status: 2'b01};
      vecs[6] = '{timeout: 7,  lat: 2,  stall: 2, exp_cycles: 3,  exp_status: 2'b00};

      reset         = 1'b0;
      cfg_valid     = 1'b0;
      cfg_num_runs  = '0;
      cfg_timeout   = '0;
      acc_done_port = 1'b0;
      res_ready     = 1'b0;
      #3;
      check_reset_values("por");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_reset_values("post_rst");

      // Single-run table.
      for (int v = 0; v < 7; v++) begin
         start_job(1, vecs[v].timeout);
         do_run(0, vecs[v].lat, vecs[v].stall, vecs[v].exp_cycles, vecs[v].exp_status, 1'b0);
         end_job();
      end

      // Three runs, stall on run 1, config poked while busy.
      start_job(3, 0);
      do_run(0, 3, 0, 4, 2'b00, 1'b1);
      do_run(1, 3, 4, 4, 2'b00, 1'b0);
      do_run(2, 3, 0, 4, 2'b00, 1'b0);
      end_job();

      // Timeout followed by a normal run.
      start_job(2, 10);
      do_run(0, -1, 0, 10, 2'b01, 1'b0);
      do_run(1, 2, 0, 3, 2'b00, 1'b0);
      end_job();

      // Zero-run job.
      start_job(0, 0);
      check("zero_all_done", all_done, 1);
      check("zero_busy", busy, 0);
      check("zero_start", acc_start_port, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("zero_idle_start", acc_start_port, 0);
         check("zero_idle_busy", busy, 0);
         check("zero_idle_done", all_done, 0);
      end

      // Reset asserted in WAIT of run 1 of 3.
      start_job(3, 0);
      do_run(0, 1, 0, 2, 2'b00, 1'b0);
      begin
         int w = 0;
         while (!acc_start_port && w < 20) begin
            @(negedge clock);
            w++;
         end
         check("mid_start_seen", acc_start_port, 1);
      end
      @(negedge clock);
      @(negedge clock);
      check("mid_in_wait_busy", busy, 1);
      check("mid_in_wait_index", res_index, 1);
      #2 reset = 1'b0;
      #1 check_reset_values("mid_rst");
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("abandon_valid", res_valid, 0);
         check("abandon_done", all_done, 0);
         check("abandon_busy", busy, 0);
      end
      start_job(1, 0);
      do_run(0, 2, 0, 3, 2'b00, 1'b0);
      end_job();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hls_run_controller.md
HLS_RUN_CONTROLLER -- requirements
Module: hls_run_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning width of the cycle counter and timeout.
REQ-002 SHALL have parameter RUN_W, default 16, meaning width of the run-count and run-index fields.
REQ-003 SHALL have parameter RST_CYCLES, default 2, meaning number of cycles the accelerator reset is held before each run.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cfg_valid, input, 1 bit: a job request is presented.
REQ-007 SHALL have port cfg_ready, output, 1 bit: the block accepts a job request.
REQ-008 SHALL have port cfg_num_runs, input, RUN_W bits: number of accelerator runs in the job.
REQ-009 SHALL have port cfg_timeout, input, CNT_W bits: per-run cycle limit; 0 disables the limit.
REQ-010 SHALL have port acc_reset, output, 1 bit: active-low reset to the accelerator.
REQ-011 SHALL have port acc_start_port, output, 1 bit: start pulse to the accelerator.
REQ-012 SHALL have port acc_done_port, input, 1 bit: done indication from the accelerator.
REQ-013 SHALL have port res_valid, output, 1 bit: a per-run result is presented.
REQ-014 SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-015 SHALL have port res_cycles, output, CNT_W bits: measured cycles for the run.
REQ-016 SHALL have port res_index, output, RUN_W bits: zero-based index of the run.
REQ-017 SHALL have port res_status, output, 2 bits: 00 = OK, 01 = TIMEOUT.
REQ-018 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-019 SHALL have port all_done, output, 1 bit: one-cycle pulse when a job completes.

Function
REQ-020 FSM states SHALL be IDLE, RST, START, WAIT, REPORT.
REQ-021 cfg_ready SHALL equal (state == IDLE); a job is accepted on any edge where cfg_valid && cfg_ready, latching cfg_num_runs and cfg_timeout.
REQ-022 Accepting a job with cfg_num_runs = 0 SHALL keep the FSM in IDLE and pulse all_done in the next cycle.
REQ-023 Accepting a job with cfg_num_runs > 0 SHALL move IDLE -> RST, with the run index cleared to 0.
REQ-024 In RST, acc_reset SHALL be 0 for exactly RST_CYCLES cycles, after which the FSM moves to START.
REQ-025 acc_reset SHALL be 0 in IDLE and RST, and 1 in START, WAIT and REPORT.
REQ-026 In START, acc_start_port SHALL be 1 for exactly one cycle, with the cycle counter loaded to 1; the FSM then moves to WAIT. acc_start_port SHALL be 0 in all other states.
REQ-027 In WAIT, the counter SHALL increment by 1 per cycle and saturate at all-ones.
REQ-028 acc_done_port sampled high at an edge in START or WAIT SHALL capture res_cycles = the counter value of that cycle, set res_status = 00, and move to REPORT.
REQ-029 When cfg_timeout != 0 and the counter equals cfg_timeout with done low, the block SHALL capture res_cycles = cfg_timeout, set res_status = 01, and move to REPORT.
REQ-030 Done and timeout in the same cycle SHALL report OK.
REQ-031 acc_done_port SHALL be ignored outside START and WAIT.
REQ-032 In REPORT, res_valid SHALL be 1, and res_cycles, res_index and res_status SHALL be held stable until res_valid && res_ready.
REQ-033 On the REPORT handshake: if index + 1 < num_runs, the block SHALL increment the index and go to RST; otherwise it SHALL go to IDLE and pulse all_done.
REQ-034 Configuration inputs SHALL be ignored while busy.

Reset
REQ-035 Reset SHALL apply asynchronously on reset = 0 and release synchronously to clock.
REQ-036 During and after reset: state = IDLE, acc_reset = 0, acc_start_port = 0, res_valid = 0, res_cycles = 0, res_index = 0, res_status = 00, busy = 0, all_done = 0, cfg_ready = 1.
REQ-037 Reset mid-run SHALL abandon the job with no result or all_done emitted.

Structure
REQ-038 A shared package SHALL hold the state enumeration, the res_status encodings (OK = 00, TIMEOUT = 01), and the default CNT_W/RUN_W constants.
REQ-039 One sub-module, hls_cycle_counter, SHALL implement the load/increment/saturate counter with a compare-equal output; all other logic SHALL reside in the top module.

Verification
REQ-040 num_runs = 1, timeout = 0, accelerator asserts done 5 cycles after the start pulse -> acc_reset low 2 cycles, one start pulse, res_cycles = 6, status 00, index 0, all_done after the handshake.
REQ-041 num_runs = 3, done at latencies 3/3/3, res_ready held low 4 cycles on run 1 -> three results, indices 0/1/2, outputs stable while stalled, RST precedes every start.
REQ-042 timeout = 10, done never asserted -> res_cycles = 10, status 01; the next run starts after RST.
REQ-043 timeout = 4, done coincident with the count reaching 4 -> status 00, res_cycles = 4.
REQ-044 num_runs = 0 -> no acc_start_port pulse, all_done one cycle after acceptance, busy stays 0.
REQ-045 reset asserted in WAIT of run 1 of 3 -> all outputs at reset values immediately; after release, a new job with num_runs = 1 runs normally.
